// File: rtl/mem_scanout_fetcher.sv
// Frame-buffer scan-out fetcher: reads one frame of packed pixel words from RAM
// port B starting at a latched base address, holds them in a credit-limited
// prefetch FIFO, and unpacks them into pixels (lane 0 = LSBs) on pix_req demand.
//
// Consumer handshake: pix_req is a one-cycle demand strobe with no back-pressure.
// The pixel answering a pix_req sampled at edge N is presented at edge N+1 with
// pix_valid=1. If the FIFO is empty mid-frame, pix_valid stays 0 and underflow
// sets (sticky until the next frame_start). Once the frame is exhausted,
// pix_req is ignored.
module mem_scanout_fetcher #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int PIX_W      = 8,
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int FIFO_DEPTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] frame_base,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              pix_req,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  output logic              underflow,
  output logic              busy,
  output logic [1:0]        fsm_state
);

  localparam int PPW         = DATA_W / PIX_W;
  localparam int FRAME_PIX   = H_RES * V_RES;
  localparam int FRAME_WORDS = (FRAME_PIX + PPW - 1) / PPW;
  localparam int WI_W        = $clog2(FRAME_WORDS + 1);
  localparam int PC_W        = $clog2(FRAME_PIX + 1);
  localparam int LANE_W      = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state;
  logic [ADDR_W-1:0]       base_q;
  logic [WI_W-1:0]         word_idx;
  logic [RD_LATENCY-1:0]   vld;
  logic [DATA_W-1:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        fifo_count;
  logic [LANE_W-1:0]       lane;
  logic [PC_W-1:0]         pix_cnt;

  logic [3:0]              inflight;
  logic [15:0]             credit_used;
  logic                    can_issue;
  logic                    push;
  logic                    pop;
  logic                    frame_left;
  logic                    serve;
  logic                    starve;
  logic                    last_pix;
  logic [DATA_W-1:0]       shifted;
  logic [PIX_W-1:0]        head_pix;

  assign busy      = (state != IDLE);
  assign fsm_state = state;

  // Credit accounting: reads on the bus plus reads in the return pipe plus buffered words.
  always_comb begin
    inflight = 4'(mem_rd);
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + 4'(vld[i]);
    end
    credit_used = 16'(fifo_count) + 16'(inflight);
    can_issue   = enable && (credit_used < 16'(FIFO_DEPTH));
  end

  // Consumer-side decisions and lane selection from the FIFO head word.
  always_comb begin
    push       = vld[RD_LATENCY-1] && !frame_start;
    frame_left = (pix_cnt != PC_W'(FRAME_PIX));
    last_pix   = (pix_cnt == PC_W'(FRAME_PIX - 1));
    serve      = pix_req && !frame_start && (state != IDLE) && frame_left && (fifo_count != '0);
    starve     = pix_req && !frame_start && (state != IDLE) && frame_left && (fifo_count == '0);
    pop        = serve && ((lane == LANE_W'(PPW - 1)) || last_pix);
    shifted    = fifo_mem[rd_ptr] >> (int'(lane) * PIX_W);
    head_pix   = shifted[PIX_W-1:0];
  end

  // Fetch FSM: issues credit-limited reads for one frame, restarted by frame_start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      base_q   <= '0;
      word_idx <= '0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
    end else if (frame_start) begin
      base_q   <= frame_base;
      word_idx <= '0;
      mem_rd   <= 1'b0;
      state    <= enable ? FETCH : IDLE;
    end else begin
      case (state)
        FETCH: begin
          if (can_issue) begin
            mem_rd   <= 1'b1;
            mem_addr <= base_q + ADDR_W'(word_idx);
            word_idx <= word_idx + 1'b1;
            if (word_idx == WI_W'(FRAME_WORDS - 1)) state <= DONE;
          end else begin
            mem_rd <= 1'b0;
          end
        end
        default: mem_rd <= 1'b0;
      endcase
    end
  end

  // Return-valid pipeline; frame_start kills every read still in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= '0;
    end else if (frame_start) begin
      vld <= '0;
    end else begin
      vld[0] <= mem_rd;
      for (int i = 1; i < RD_LATENCY; i++) vld[i] <= vld[i-1];
    end
  end

  // FIFO storage: data only, emptiness is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_rdata;
  end

  // FIFO bookkeeping and registered pixel output path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      lane       <= '0;
      pix_cnt    <= '0;
      pix_data   <= '0;
      pix_valid  <= 1'b0;
      underflow  <= 1'b0;
    end else if (frame_start) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      lane       <= '0;
      pix_cnt    <= '0;
      pix_valid  <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      pix_valid  <= serve;
      if (serve) begin
        pix_data <= head_pix;
        pix_cnt  <= pix_cnt + 1'b1;
        lane     <= pop ? '0 : lane + 1'b1;
      end else if (starve) begin
        pix_data  <= '0;
        underflow <= 1'b1;
      end
    end
  end

endmodule
